parallel_pe_param: RTL and testbench
====================================

Name: parallel_pe_param

Overview:
Parametrised successor to the fixed 32-lane x 16-bit parallel_pe.
- Computes a signed dot product of LANES neuron/weight element pairs per valid beat.
- Accumulates beat sums over a group framed by first/last control bits.
- Emits one OUT_W-bit result per group, with optional signed saturation and an overflow flag.
- Sits between the neuron/weight SRAM read ports and the result writeback/compare logic.

Parameters:
LANES, 32, number of multiply lanes (power of two, >=2)
DW, 16, signed element width of neuron and weight
ACC_W, 48, internal accumulator width; must be >= 2*DW+log2(LANES)
OUT_W, 32, result width (OUT_W <= ACC_W)
SAT, 0, 0 = result is low OUT_W bits of accumulator; 1 = signed saturate to OUT_W range

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  asynchronous active-low reset
neuron  in  LANES*DW  packed signed elements; lane i = bits [i*DW +: DW]
weight  in  LANES*DW  packed signed elements, same packing
ctl  in  2  ctl[0] = first beat of group (clear accumulator); ctl[1] = last beat (emit result)
vld_i  in  1  beat valid; neuron/weight/ctl ignored when low
result  out  OUT_W  group result, valid while vld_o high
vld_o  out  1  one-cycle result strobe
ovf_o  out  1  accumulator outside signed OUT_W range at emit; valid with vld_o

Behaviour:
- Reset (async assert, sync release): all pipeline valid bits, first/last tags, products, tree sum and accumulator clear to 0. result=0, vld_o=0, ovf_o=0.
- Reset mid-group discards the partial accumulation; no result is emitted for that group.
- Stage 1, registered at the end of cycle n:
  - LANES signed DW x DW products, each 2*DW bits.
  - Stage valid, first and last tags captured from vld_i, ctl[0], ctl[1].
- Stage 2, end of n+1: signed adder tree, sign-extended to ACC_W; tags forwarded.
- Stage 3, end of n+2: accumulator update.
  - If first tag set: acc = sum.
  - Otherwise: acc = acc + sum, wrapping two's complement at ACC_W.
  - If last tag set: result/ovf_o/vld_o are loaded on the same edge.
- Latency: a beat with ctl[1] presented in cycle n produces vld_o=1 during cycle n+3, for exactly one cycle.
- Throughput: one beat per cycle, no stall, no ready signal.
- vld_i=0 bubbles inject invalid slots. The accumulator and outputs hold across bubbles, and ctl is don't-care during them.
- ctl=2'b11 on one beat: single-beat group; result reflects that beat's sum alone.
- Back-to-back groups (last on beat k, first on beat k+1) give results on consecutive cycles.
- Missing ctl[0] after a ctl[1]: accumulation continues from the previous group's acc value. This is defined behaviour, not an error.
- Output formation:
  - ovf_o=1 iff signed acc_next > 2^(OUT_W-1)-1 or < -2^(OUT_W-1).
  - SAT=0: result = acc_next[OUT_W-1:0].
  - SAT=1: result clamps to 0x7FF..F or 0x800..0 when ovf_o=1, else the low bits.
- Between strobes: result holds its last value and ovf_o holds; both are only meaningful while vld_o=1.

Test Plan:
1. Default params; one beat ctl=11, all lanes neuron=1, weight=1 in cycle n -> vld_o=1 in cycle n+3 only, result=32, ovf_o=0.
2. Four consecutive beats (ctl 01,00,00,10) with neuron=2, weight=3 -> single vld_o three cycles after the 4th beat, result=768 (4x192).
3. Same four beats with a one-cycle vld_i=0 bubble between each, carrying ctl=11 garbage, followed immediately by a second 1-beat group of all ones. Required response:
   - result=768 exactly once;
   - result=32 on the very next cycle;
   - no other vld_o.
4. One beat ctl=11, neuron=0xFFFF (-1), weight=0x0002 -> result=0xFFFFFFC0 (-64), ovf_o=0.
5. One beat ctl=11, neuron=weight=0x7FFF (sum 0x7FFE00020):
   - SAT=0 -> result=0xFFE00020, ovf_o=1;
   - SAT=1 -> result=0x7FFFFFFF, ovf_o=1.
6. Start a 4-beat group (neuron=2, weight=3); drop rst_n for 2 cycles after beat 2.
   - During reset: outputs read 0 immediately, and no vld_o appears for the aborted group.
   - After release: a 1-beat all-ones group returns result=32.

Source files
------------

// File: rtl/parallel_pe_param.sv
// parallel_pe_param: LANES-wide signed dot-product processing element.
// Three registered stages: lane products, adder tree, group accumulator.
// Groups are framed by ctl[0] (first beat, clears acc) and ctl[1] (last
// beat, emits result). A result leaves as a one-cycle vld_o strobe with an
// overflow flag. Optionally the result saturates to the signed OUT_W range.
module parallel_pe_param #(
  parameter int LANES = 32,
  parameter int DW    = 16,
  parameter int ACC_W = 48,
  parameter int OUT_W = 32,
  parameter int SAT   = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [LANES*DW-1:0]   neuron,
  input  logic [LANES*DW-1:0]   weight,
  input  logic [1:0]            ctl,
  input  logic                  vld_i,
  output logic [OUT_W-1:0]      result,
  output logic                  vld_o,
  output logic                  ovf_o
);

  localparam int PW = 2 * DW;

  // ---------------------------------------------------------------------
  // Helper functions
  // ---------------------------------------------------------------------

  // The value fits the signed OUT_W range only when every bit from the
  // OUT_W sign position up to the accumulator MSB is equal.
  function automatic logic out_of_range(input logic [ACC_W-1:0] a);
    logic [ACC_W-OUT_W:0] top;
    top = a[ACC_W-1:OUT_W-1];
    return !((&top) || (~|top));
  endfunction

  // Form the output word. When saturation is enabled and the value is out
  // of range, clamp it toward the side given by the accumulator sign.
  function automatic logic [OUT_W-1:0] form_result(input logic [ACC_W-1:0] a,
                                                   input logic ovf);
    logic [OUT_W-1:0] r;
    if ((SAT != 0) && ovf) begin
      if (a[ACC_W-1]) begin
        r = {1'b1, {(OUT_W-1){1'b0}}};
      end else begin
        r = {1'b0, {(OUT_W-1){1'b1}}};
      end
    end else begin
      r = a[OUT_W-1:0];
    end
    return r;
  endfunction

  // ---------------------------------------------------------------------
  // Stage 1: lane products
  // ---------------------------------------------------------------------
  logic signed [PW-1:0] prod_s [LANES];
  logic signed [PW-1:0] prod_r [LANES];
  logic                 v1_r;
  logic                 f1_r;
  logic                 l1_r;

  // Form one full-width signed product per lane. Each operand is
  // sign-extended before the multiply so that no product bits are lost.
  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      prod_s[i] = PW'($signed(neuron[i*DW +: DW])) *
                  PW'($signed(weight[i*DW +: DW]));
    end
  end

  // Register the products. The first/last tags are qualified by vld_i so
  // that ctl can be garbage during bubbles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_r <= 1'b0;
      f1_r <= 1'b0;
      l1_r <= 1'b0;
      for (int i = 0; i < LANES; i++) begin
        prod_r[i] <= '0;
      end
    end else begin
      v1_r <= vld_i;
      f1_r <= vld_i & ctl[0];
      l1_r <= vld_i & ctl[1];
      if (vld_i) begin
        for (int i = 0; i < LANES; i++) begin
          prod_r[i] <= prod_s[i];
        end
      end
    end
  end

  // ---------------------------------------------------------------------
  // Stage 2: signed adder tree
  // ---------------------------------------------------------------------
  logic signed [ACC_W-1:0] tree_s [LANES];
  logic signed [ACC_W-1:0] sum_r;
  logic                    v2_r;
  logic                    f2_r;
  logic                    l2_r;

  // Binary reduction done in place. At each level, node i absorbs node
  // i+step, and node 0 ends up holding the total. Leaves are sign-extended
  // to ACC_W, so the tree never overflows for legal parameters.
  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      tree_s[i] = {{(ACC_W-PW){prod_r[i][PW-1]}}, prod_r[i]};
    end
    for (int step = 1; step < LANES; step = step * 2) begin
      for (int i = 0; i < LANES; i = i + 2 * step) begin
        tree_s[i] = tree_s[i] + tree_s[i+step];
      end
    end
  end

  // Register the beat sum and forward the tags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2_r  <= 1'b0;
      f2_r  <= 1'b0;
      l2_r  <= 1'b0;
      sum_r <= '0;
    end else begin
      v2_r <= v1_r;
      f2_r <= f1_r;
      l2_r <= l1_r;
      if (v1_r) begin
        sum_r <= tree_s[0];
      end
    end
  end

  // ---------------------------------------------------------------------
  // Stage 3: group accumulator and output formation
  // ---------------------------------------------------------------------
  logic signed [ACC_W-1:0] acc_r;
  logic signed [ACC_W-1:0] acc_next_s;
  logic                    ovf_s;
  logic [OUT_W-1:0]        res_s;

  // A first beat restarts the group. Any other beat adds onto the running
  // value, including a beat that arrives after a last beat without a new
  // first beat. The sum wraps at ACC_W.
  always_comb begin
    acc_next_s = sum_r;
    if (f2_r) begin
      acc_next_s = sum_r;
    end else begin
      acc_next_s = acc_r + sum_r;
    end
    ovf_s = out_of_range(acc_next_s);
    res_s = form_result(acc_next_s, ovf_s);
  end

  // Update the accumulator on valid slots only. Result and overflow load
  // only on the last beat and hold between strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_r  <= '0;
      result <= '0;
      ovf_o  <= 1'b0;
      vld_o  <= 1'b0;
    end else begin
      vld_o <= v2_r & l2_r;
      if (v2_r) begin
        acc_r <= acc_next_s;
      end
      if (v2_r && l2_r) begin
        result <= res_s;
        ovf_o  <= ovf_s;
      end
    end
  end

endmodule

// File: tb/tb_parallel_pe_param.sv
// Testbench for parallel_pe_param. It runs two instances that share the
// same stimulus: one with wrapped output and one with saturated output.
// A behavioural dot-product/accumulate model predicts each output strobe
// three cycles after the beat that carries the last tag.
module tb_parallel_pe_param;

  localparam int LANES = 32;
  localparam int DW    = 16;
  localparam int VW    = LANES * DW;

  logic          clk;
  logic          rst_n;
  logic [VW-1:0] neuron;
  logic [VW-1:0] weight;
  logic [1:0]    ctl;
  logic          vld_i;
  logic [31:0]   result0, result1;
  logic          vld_o0, vld_o1;
  logic          ovf_o0, ovf_o1;

  parallel_pe_param #(.LANES(32), .DW(16), .ACC_W(48), .OUT_W(32), .SAT(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .neuron(neuron), .weight(weight), .ctl(ctl),
    .vld_i(vld_i), .result(result0), .vld_o(vld_o0), .ovf_o(ovf_o0)
  );

  parallel_pe_param #(.LANES(32), .DW(16), .ACC_W(48), .OUT_W(32), .SAT(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .neuron(neuron), .weight(weight), .ctl(ctl),
    .vld_i(vld_i), .result(result1), .vld_o(vld_o1), .ovf_o(ovf_o1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          v;
    logic [31:0] r0;
    logic [31:0] r1;
    bit          o;
  } exp_t;

  exp_t               q[$];
  logic signed [47:0] macc;
  int                 n_cmp;
  int                 n_bad;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [VW-1:0] fill(input logic [15:0] x);
    return {LANES{x}};
  endfunction

  function automatic logic [VW-1:0] rnd_vec(input int mode);
    logic [VW-1:0] v;
    logic [15:0]   lane;
    for (int i = 0; i < LANES; i++) begin
      if (mode == 0) lane = 16'($urandom);
      else           lane = 16'($urandom_range(0, 15)) - 16'd8;
      v[i*DW +: DW] = lane;
    end
    return v;
  endfunction

  function automatic longint dot(input logic [VW-1:0] nv, input logic [VW-1:0] wv);
    longint s;
    logic signed [15:0] a, b;
    s = 0;
    for (int i = 0; i < LANES; i++) begin
      a = nv[i*DW +: DW];
      b = wv[i*DW +: DW];
      s = s + longint'(a) * longint'(b);
    end
    return s;
  endfunction

  task automatic prime_queue();
    exp_t z;
    z = '{v: 1'b0, r0: 32'd0, r1: 32'd0, o: 1'b0};
    q.delete();
    q.push_back(z);
    q.push_back(z);
  endtask

  // Present one slot for a cycle, then compare against the prediction made
  // for the slot that entered two cycles earlier.
  task automatic step(input bit v, input logic [1:0] c,
                      input logic [VW-1:0] nv, input logic [VW-1:0] wv);
    exp_t   e;
    longint s, m;
    neuron = nv;
    weight = wv;
    ctl    = c;
    vld_i  = v;
    e = '{v: 1'b0, r0: 32'd0, r1: 32'd0, o: 1'b0};
    if (v) begin
      s = dot(nv, wv);
      if (c[0]) macc = 48'(s);
      else      macc = macc + 48'(s);
      if (c[1]) begin
        m    = longint'(macc);
        e.v  = 1'b1;
        e.o  = (m > 64'sd2147483647) || (m < -64'sd2147483648);
        e.r0 = m[31:0];
        if (e.o) e.r1 = (m > 0) ? 32'h7FFF_FFFF : 32'h8000_0000;
        else     e.r1 = m[31:0];
      end
    end
    q.push_back(e);
    @(posedge clk);
    #1;
    e = q.pop_front();
    check("vld_o0", 64'(vld_o0), 64'(e.v));
    check("vld_o1", 64'(vld_o1), 64'(e.v));
    if (e.v) begin
      check("result0", 64'(result0), 64'(e.r0));
      check("result1", 64'(result1), 64'(e.r1));
      check("ovf_o0", 64'(ovf_o0), 64'(e.o));
      check("ovf_o1", 64'(ovf_o1), 64'(e.o));
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 2'($urandom), rnd_vec(0), rnd_vec(0));
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_vld0"}, 64'(vld_o0), 64'd0);
    check({tag, "_vld1"}, 64'(vld_o1), 64'd0);
    check({tag, "_res0"}, 64'(result0), 64'd0);
    check({tag, "_res1"}, 64'(result1), 64'd0);
    check({tag, "_ovf0"}, 64'(ovf_o0), 64'd0);
    check({tag, "_ovf1"}, 64'(ovf_o1), 64'd0);
  endtask

  // Assert reset off the clock edge and hold it for two cycles. The
  // pipeline and any partial group are discarded.
  task automatic do_reset();
    vld_i = 1'b0;
    rst_n = 1'b0;
    #1;
    check_zero("rst_now");
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      check_zero("rst_hold");
    end
    rst_n = 1'b1;
    macc  = 48'sd0;
    prime_queue();
  endtask

  initial begin
    n_cmp  = 0;
    n_bad  = 0;
    macc   = 48'sd0;
    rst_n  = 1'b0;
    vld_i  = 1'b0;
    ctl    = 2'b00;
    neuron = '0;
    weight = '0;
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    rst_n = 1'b1;
    prime_queue();

    // Test 1: single-beat group of all ones.
    step(1'b1, 2'b11, fill(16'd1), fill(16'd1));
    idle(3);

    // Test 2: four-beat group.
    step(1'b1, 2'b01, fill(16'd2), fill(16'd3));
    step(1'b1, 2'b00, fill(16'd2), fill(16'd3));
    step(1'b1, 2'b00, fill(16'd2), fill(16'd3));
    step(1'b1, 2'b10, fill(16'd2), fill(16'd3));
    idle(4);

    // Test 3: the same group with garbage bubbles, then a 1-beat group.
    step(1'b1, 2'b01, fill(16'd2), fill(16'd3));
    step(1'b0, 2'b11, rnd_vec(0), rnd_vec(0));
    step(1'b1, 2'b00, fill(16'd2), fill(16'd3));
    step(1'b0, 2'b11, rnd_vec(0), rnd_vec(0));
    step(1'b1, 2'b00, fill(16'd2), fill(16'd3));
    step(1'b0, 2'b11, rnd_vec(0), rnd_vec(0));
    step(1'b1, 2'b10, fill(16'd2), fill(16'd3));
    step(1'b1, 2'b11, fill(16'd1), fill(16'd1));
    idle(4);

    // Test 4: negative result.
    step(1'b1, 2'b11, fill(16'hFFFF), fill(16'h0002));
    idle(3);

    // Test 5: overflow, which wraps in dut0 and saturates in dut1.
    step(1'b1, 2'b11, fill(16'h7FFF), fill(16'h7FFF));
    idle(3);

    // Test 6: reset in the middle of a group, then a fresh group.
    step(1'b1, 2'b01, fill(16'd2), fill(16'd3));
    step(1'b1, 2'b00, fill(16'd2), fill(16'd3));
    do_reset();
    step(1'b1, 2'b11, fill(16'd1), fill(16'd1));
    idle(4);

    // A group that continues after a last beat without a new first beat.
    step(1'b1, 2'b11, fill(16'd1), fill(16'd1));
    step(1'b1, 2'b10, fill(16'd1), fill(16'd1));
    idle(3);

    // Random traffic with bubbles, random framing and mixed magnitudes.
    for (int k = 0; k < 600; k++) begin
      int mode;
      mode = int'($urandom_range(0, 1));
      step(($urandom_range(0, 9) < 8), 2'($urandom), rnd_vec(mode), rnd_vec(mode));
      if (k == 300) do_reset();
    end
    idle(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
